// File: rtl/inst_encoder.sv
// inst_encoder: packs field-level RV32IM encode requests into 32-bit words,
// expands LI into LUI+ADDI, tags words with byte addresses and queues them
// in a small FIFO for the instruction-memory loader.
// Optional M extension: define INST_ENCODER_MULDIV_EN to accept MUL/MULH/
// MULHSU/MULHU in the R class; otherwise those codes are rejected.
// ALU code map (mirrors the core's ALU_* definitions):
//   0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND
//   10 PASS_A 11 PASS_B 12 MUL 13 MULH 14 MULHSU 15 MULHU
module inst_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_op,
  input  logic [3:0]               req_alu,
  input  logic [2:0]               req_f3,
  input  logic [4:0]               req_rd,
  input  logic [4:0]               req_rs1,
  input  logic [4:0]               req_rs2,
  input  logic [31:0]              req_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_addr,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  // request classes
  localparam logic [3:0] OP_R      = 4'd0;
  localparam logic [3:0] OP_OPIMM  = 4'd1;
  localparam logic [3:0] OP_LOAD   = 4'd2;
  localparam logic [3:0] OP_STORE  = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_LUI    = 4'd5;
  localparam logic [3:0] OP_AUIPC  = 4'd6;
  localparam logic [3:0] OP_JAL    = 4'd7;
  localparam logic [3:0] OP_JALR   = 4'd8;
  localparam logic [3:0] OP_LI     = 4'd9;

  // ALU codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
`ifdef INST_ENCODER_MULDIV_EN
  localparam logic [3:0] ALU_MUL    = 4'd12;
  localparam logic [3:0] ALU_MULH   = 4'd13;
  localparam logic [3:0] ALU_MULHSU = 4'd14;
  localparam logic [3:0] ALU_MULHU  = 4'd15;
`endif

  // RV32 major opcodes
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [0:0] {IDLE = 1'b0, LI_LO = 1'b1} state_t;

  // funct3 for an ALU code (R and OP_IMM share it)
  function automatic logic [2:0] alu_f3(input logic [3:0] alu);
    case (alu)
      ALU_ADD, ALU_SUB: alu_f3 = 3'd0;
      ALU_SLL:          alu_f3 = 3'd1;
      ALU_SLT:          alu_f3 = 3'd2;
      ALU_SLTU:         alu_f3 = 3'd3;
      ALU_XOR:          alu_f3 = 3'd4;
      ALU_SRL, ALU_SRA: alu_f3 = 3'd5;
      ALU_OR:           alu_f3 = 3'd6;
      ALU_AND:          alu_f3 = 3'd7;
`ifdef INST_ENCODER_MULDIV_EN
      ALU_MUL:          alu_f3 = 3'd0;
      ALU_MULH:         alu_f3 = 3'd1;
      ALU_MULHSU:       alu_f3 = 3'd2;
      ALU_MULHU:        alu_f3 = 3'd3;
`endif
      default:          alu_f3 = 3'd0;
    endcase
  endfunction

  // funct7 for an R-class ALU code
  function automatic logic [6:0] r_f7(input logic [3:0] alu);
    case (alu)
      ALU_SUB, ALU_SRA: r_f7 = 7'h20;
`ifdef INST_ENCODER_MULDIV_EN
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: r_f7 = 7'h01;
`endif
      default:          r_f7 = 7'h00;
    endcase
  endfunction

  // ALU codes that have an R-class encoding
  function automatic logic r_legal(input logic [3:0] alu);
`ifdef INST_ENCODER_MULDIV_EN
    r_legal = (alu <= ALU_AND) || (alu >= ALU_MUL);
`else
    r_legal = (alu <= ALU_AND);
`endif
  endfunction

  // signed 12-bit immediate range
  function automatic logic fits_i(input logic [31:0] v);
    fits_i = ($signed(v) >= -32'sd2048) && ($signed(v) <= 32'sd2047);
  endfunction

  // state
  state_t               state_q, state_d;
  logic [4:0]           rd_q;
  logic [11:0]          lo_q;
  logic [31:0]          addr_q;
  logic [63:0]          mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 err_q;
  logic [1:0]           err_code_q;
  logic                 ready_q, ready_d;

  // encoder results
  logic [31:0]          enc_word;
  logic                 enc_bad;
  logic [1:0]           enc_code;
  logic                 enc_two;
  logic [19:0]          li_hi;
  logic                 is_shift;

  // control
  logic                 accept, pop, push;
  logic [31:0]          push_word;
  logic [31:0]          addi_word;

  // (imm + 0x800) >> 12 without carrying the unused low bits around
  assign li_hi     = req_imm[31:12] + {19'd0, req_imm[11]};
  assign is_shift  = (req_alu == ALU_SLL) || (req_alu == ALU_SRL) || (req_alu == ALU_SRA);
  assign addi_word = {lo_q, rd_q, 3'b000, rd_q, OPC_OPIMM};

  // range-check the request and pack it into an instruction word
  always_comb begin
    enc_word = 32'h0;
    enc_bad  = 1'b0;
    enc_code = 2'd0;
    enc_two  = 1'b0;
    case (req_op)
      OP_R: begin
        if (r_legal(req_alu)) begin
          enc_word = {r_f7(req_alu), req_rs2, req_rs1, alu_f3(req_alu), req_rd, OPC_R};
        end else begin
          enc_bad  = 1'b1;
          enc_code = 2'd1;
        end
      end
      OP_OPIMM: begin
        if ((req_alu > ALU_AND) || (req_alu == ALU_SUB)) begin
          enc_bad  = 1'b1;
          enc_code = 2'd1;
        end else if (is_shift) begin
          if (req_imm[31:5] != 27'd0) begin
            enc_bad  = 1'b1;
            enc_code = 2'd2;
          end else begin
            enc_word = {((req_alu == ALU_SRA) ? 7'h20 : 7'h00), req_imm[4:0], req_rs1,
                        alu_f3(req_alu), req_rd, OPC_OPIMM};
          end
        end else if (!fits_i(req_imm)) begin
          enc_bad  = 1'b1;
          enc_code = 2'd2;
        end else begin
          enc_word = {req_imm[11:0], req_rs1, alu_f3(req_alu), req_rd, OPC_OPIMM};
        end
      end
      OP_LOAD: begin
        if (fits_i(req_imm)) begin
          enc_word = {req_imm[11:0], req_rs1, req_f3, req_rd, OPC_LOAD};
        end else begin
          enc_bad  = 1'b1;
          enc_code = 2'd2;
        end
      end
      OP_STORE: begin
        if (fits_i(req_imm)) begin
          enc_word = {req_imm[11:5], req_rs2, req_rs1, req_f3, req_imm[4:0], OPC_STORE};
        end else begin
          enc_bad  = 1'b1;
          enc_code = 2'd2;
        end
      end
      OP_BRANCH: begin
        if (req_imm[0]) begin
          enc_bad  = 1'b1;
          enc_code = 2'd3;
        end else if (($signed(req_imm) < -32'sd4096) || ($signed(req_imm) > 32'sd4094)) begin
          enc_bad  = 1'b1;
          enc_code = 2'd2;
        end else begin
          enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_f3,
                      req_imm[4:1], req_imm[11], OPC_BRANCH};
        end
      end
      OP_LUI: begin
        enc_word = {req_imm[31:12], req_rd, OPC_LUI};
      end
      OP_AUIPC: begin
        enc_word = {req_imm[31:12], req_rd, OPC_AUIPC};
      end
      OP_JAL: begin
        if (req_imm[0]) begin
          enc_bad  = 1'b1;
          enc_code = 2'd3;
        end else if (($signed(req_imm) < -32'sd1048576) || ($signed(req_imm) > 32'sd1048574)) begin
          enc_bad  = 1'b1;
          enc_code = 2'd2;
        end else begin
          enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OPC_JAL};
        end
      end
      OP_JALR: begin
        if (fits_i(req_imm)) begin
          enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_JALR};
        end else begin
          enc_bad  = 1'b1;
          enc_code = 2'd2;
        end
      end
      OP_LI: begin
        if (fits_i(req_imm)) begin
          enc_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_OPIMM};
        end else begin
          enc_word = {li_hi, req_rd, OPC_LUI};
          enc_two  = (req_imm[11:0] != 12'd0);
        end
      end
      default: begin
        enc_bad  = 1'b1;
        enc_code = 2'd1;
      end
    endcase
  end

  // handshake, push source selection, next FSM state, occupancy and ready
  always_comb begin
    accept    = req_valid && ready_q;
    pop       = out_ready && (level_q != '0);
    push      = 1'b0;
    push_word = enc_word;
    state_d   = state_q;
    if (state_q == LI_LO) begin
      push      = (level_q < DEPTH_L);
      push_word = addi_word;
      state_d   = push ? IDLE : LI_LO;
    end else begin
      push      = accept && !enc_bad;
      push_word = enc_word;
      state_d   = (accept && !enc_bad && enc_two) ? LI_LO : IDLE;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ready_d = (state_d == IDLE) && (level_d < DEPTH_L);
  end

  // FSM, LI latch, address counter, FIFO storage and error reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_q       <= 5'd0;
      lo_q       <= 12'd0;
      addr_q     <= BASE_ADDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      ready_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 64'd0;
      end
    end else begin
      state_q <= state_d;
      if (accept && !enc_bad && enc_two) begin
        rd_q <= req_rd;
        lo_q <= req_imm[11:0];
      end
      if (push) begin
        mem_q[wr_ptr_q] <= {addr_q, push_word};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
        addr_q          <= addr_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
      err_q   <= accept && enc_bad;
      if (accept && enc_bad) begin
        err_code_q <= enc_code;
      end
      ready_q <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign out_valid = (level_q != '0);
  assign out_instr = mem_q[rd_ptr_q][31:0];
  assign out_addr  = mem_q[rd_ptr_q][63:32];
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign level     = level_q;

endmodule
